shift_arb_ctrl: RTL and testbench
=================================

# shift_arb_ctrl

Round-robin scheduler that shares one parallel-in/serial-out shift register between R requesters. A requester presents a W-bit word and holds `req`. The block arbitrates, loads the winner's word into the shifter and shifts it out MSB-first, one bit per clock, with framing strobes. It sits in front of any single-wire serial sink (LED chain, DAC/SPI-like shift path) that several producers must share.

## Interface
- `W`, 8: word width in bits; legal range W ≥ 2.
- `R`, 2: number of requesters; legal range R ≥ 2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in R: per-requester request; held high with stable `data` slice until that requester's `grant` is seen.
- `data` in R*W: requester i's word in `data[i*W +: W]`.
- `grant` out R: one-hot, one-cycle pulse; marks acceptance of requester's word.
- `sout` out 1: serial data bit.
- `sout_valid` out 1: high during every cycle that carries a payload bit.
- `frame` out 1: high with the first (MSB) bit of each word.
- `done` out 1: high with the last (LSB) bit of each word.
- `busy` out 1: high whenever state is SHIFT.

## Operation
- FSM states: IDLE, SHIFT. Reset → IDLE.
- Arbitration point: a cycle in IDLE, or the last-bit cycle of SHIFT (`cnt == 0`), with `req != 0`.
- Winner: first set bit of `req` scanning from `ptr` upward, modulo R.
- At the edge ending an arbitration cycle with winner i:
  - `shreg <= data[i]`, `cnt <= W-1`, `ptr <= (i+1) mod R`, state → SHIFT.
  - `grant`, `frame` registered to pulse in the next cycle.
- SHIFT, every cycle:
  - `sout = shreg[W-1]`, `sout_valid = 1`, `busy = 1`.
  - Each edge: `shreg <= shreg << 1`, `cnt <= cnt - 1`.
- Last-bit cycle (`cnt == 0`):
  - `done = 1`.
  - If no request, state → IDLE.
  - Otherwise back-to-back load with no gap bit.
- `cnt` width: $clog2(W). `ptr` width: $clog2(R).
- Not-granted requesters keep `req` asserted; they are served in rotation.
- Reset values: all outputs 0, `ptr = 0` (requester 0 highest priority after reset), `shreg = 0`, `cnt = 0`.
- Reset mid-word aborts the word immediately: no `done`, no further bits.
- `req` asserted while busy, outside the last-bit cycle, is ignored until the next arbitration point.
- A requester deasserting `req` before its grant is legal; it is simply not served.

## Timing
- Arbitration cycle T (IDLE, `req` seen):
  - T+1: `grant`, `frame`, `sout_valid`, `busy` high; `sout` = MSB.
  - T+W: LSB with `done`.
- Latency from `req` sampled in IDLE to first bit: 1 cycle.
- Throughput: 1 bit/cycle; continuous words with zero idle cycles when requests are pending.
- Requester contract: drop `req` (or present a new word) no later than the cycle after `grant`. With W ≥ 2 this precedes the next arbitration point.
- `busy` deasserts in the cycle after the last `done` when no request is pending.

## Structure
- Package `shift_arb_pkg`:
  - `state_t` enum {IDLE, SHIFT}.
  - Function `rr_pick(req, ptr)` returning index and found flag.
- Sub-module `piso_shift #(W)`:
  - Ports: `clk`, `rst`, `load`, `shift`, `din[W-1:0]`, `dout`.
  - Load has priority over shift.
- Top holds the FSM, counter, pointer and output registers.

## Test plan
- **Single request:** W=8, R=2, `req=01`, `data[0]=8'hA5` at T.
  - T+1..T+8: `sout` = 1,0,1,0,0,1,0,1.
  - `frame`@T+1, `done`@T+8, `grant=01`@T+1, `busy` low at T+9.
- **Simultaneous requests after reset:** `req=11`, words 8'hF0 / 8'h0F.
  - Requester 0 first.
  - Requester 1's `grant` and `frame` at T+9, directly after `done`@T+8.
  - 16 consecutive `sout_valid` cycles, bits 11110000_00001111.
- **Fairness:** `req=11` held continuously, requesters re-presenting after each grant.
  - Grants alternate 01,10,01,10 over 4 words.
  - No gap cycles.
- **Reset mid-word:** `rst` at T+4 of word 8'hFF.
  - T+5: all outputs 0, `busy=0`, no `done`.
  - Next request goes to requester 0.
- **Late request ignored:** `req[1]` rises at T+3 during requester 0's word.
  - Not granted until the arbitration point at T+8.
  - `grant=10` at T+9.
- **Withdrawn request:** `req[1]` pulses for one cycle while busy, dropped before `done`.
  - No grant.
  - FSM returns to IDLE after requester 0's word.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared types and the round-robin pick helper for shift_arb_ctrl.
//   state_t  : FSM encoding (IDLE, SHIFT)
//   pick_t   : result of rr_pick (found flag + winning index)
//   rr_pick  : first set request bit at or above ptr, wrapping modulo r
package shift_arb_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Upper bound on requester count supported by rr_pick.
    localparam int unsigned RMAX = 64;
    localparam int unsigned IDXW = 6;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [RMAX-1:0] req,
                                      input int unsigned     ptr,
                                      input int unsigned     r);
        pick_t       p;
        int unsigned j;
        p.found = 1'b0;
        p.idx   = '0;
        for (int unsigned k = 0; k < RMAX; k++) begin
            if (k < r) begin
                j = ptr + k;
                if (j >= r) begin
                    j = j - r;
                end
                if (!p.found && req[j[IDXW-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = j[IDXW-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/shift_arb_ctrl_if.sv
// Requester/sink bundle for shift_arb_ctrl.
//   req[R], data[R*W]          : requester side (word i in data[i*W +: W])
//   grant[R]                   : one-hot acceptance pulse
//   sout, sout_valid, frame,
//   done, busy                 : serial output and framing strobes
// Modports: master (requesters + sink), slave (the arbiter).
interface shift_arb_ctrl_if #(
    parameter int unsigned W = 8,
    parameter int unsigned R = 2
);
    logic [R-1:0]   req;
    logic [R*W-1:0] data;
    logic [R-1:0]   grant;
    logic           sout;
    logic           sout_valid;
    logic           frame;
    logic           done;
    logic           busy;

    modport master (
        output req, data,
        input  grant, sout, sout_valid, frame, done, busy
    );

    modport slave (
        input  req, data,
        output grant, sout, sout_valid, frame, done, busy
    );
endinterface

// File: rtl/shift_arb_ctrl_piso.sv
// Parallel-in/serial-out shift register, MSB first.
//   clk, rst : clock, synchronous active-high reset (clears register)
//   load     : capture din (wins over shift)
//   shift    : shift left by one, zero fill
//   din[W]   : parallel word
//   dout     : current MSB
module piso_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[W-2:0], 1'b0};
        end
    end

    assign dout = shreg[W-1];
endmodule

// File: rtl/shift_arb_ctrl.sv
// Round-robin scheduler sharing one PISO shifter among R requesters.
//   clk : clock (rising edge)
//   rst : synchronous active-high reset
//   bus : shift_arb_ctrl_if.slave -- req/data in; grant, sout,
//         sout_valid, frame, done, busy out
// A word is granted at an arbitration point (IDLE, or the last-bit cycle
// of SHIFT) and shifted out MSB-first starting the following cycle.
module shift_arb_ctrl
    import shift_arb_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned R = 2
) (
    input  logic          clk,
    input  logic          rst,
    shift_arb_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned PW = $clog2(R);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [R-1:0]  grant_q;
    logic          frame_q;
    logic          load, shift, last, dout;
    logic [W-1:0]  din;
    pick_t         pick;

    assign last = (cnt == '0);

    always_comb begin
        pick = rr_pick(RMAX'(bus.req), 32'(ptr), R);
    end

    always_comb begin
        din = bus.data[32'(pick.idx)*W +: W];
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    // Reloading on the last-bit edge keeps the stream gapless;
                    // load outranks shift inside the shifter.
                    if (pick.found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            grant_q <= '0;
            frame_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            frame_q <= load;
            grant_q <= load ? (R'(1) << pick.idx) : '0;
            if (load) begin
                cnt <= CW'(W - 1);
                if (32'(pick.idx) + 1 >= R) begin
                    ptr <= '0;
                end else begin
                    ptr <= PW'(32'(pick.idx) + 1);
                end
            end else if (state == SHIFT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    piso_shift #(.W(W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (din),
        .dout  (dout)
    );

    assign bus.busy       = (state == SHIFT);
    assign bus.sout_valid = (state == SHIFT);
    assign bus.sout       = (state == SHIFT) & dout;
    assign bus.done       = (state == SHIFT) & last;
    assign bus.grant      = grant_q;
    assign bus.frame      = frame_q;
endmodule

// File: tb/tb_shift_arb_ctrl.sv
module tb_shift_arb_ctrl;
    import shift_arb_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned R = 2;

    logic clk;
    logic rst;
    int   nvec;
    int   nmiss;

    shift_arb_ctrl_if #(.W(W), .R(R)) bus ();

    shift_arb_ctrl #(.W(W), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {grant, sout, sout_valid, frame, done, busy}
    function automatic logic [6:0] obs();
        return {bus.grant, bus.sout, bus.sout_valid, bus.frame, bus.done, bus.busy};
    endfunction

    task automatic expect_idle(input string tag);
        tick();
        chk({tag, ".idle"}, 32'(obs()), 32'd0);
    endtask

    // Check one full word starting the cycle after the arbitration cycle.
    // drop: req bits cleared once the grant is seen.
    // ev: req bits raised at cycle set_k and cleared at cycle clr_k.
    task automatic expect_word(input string tag, input logic [R-1:0] gnt,
                               input logic [W-1:0] word, input logic [R-1:0] drop,
                               input int set_k, input int clr_k, input logic [R-1:0] ev);
        for (int k = 1; k <= int'(W); k++) begin
            tick();
            chk($sformatf("%s.k%0d.grant", tag, k), 32'(bus.grant), (k == 1) ? 32'(gnt) : 32'd0);
            chk($sformatf("%s.k%0d.sout", tag, k), 32'(bus.sout), 32'(word[W-k]));
            chk($sformatf("%s.k%0d.valid", tag, k), 32'(bus.sout_valid), 32'd1);
            chk($sformatf("%s.k%0d.frame", tag, k), 32'(bus.frame), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s.k%0d.done", tag, k), 32'(bus.done), (k == int'(W)) ? 32'd1 : 32'd0);
            chk($sformatf("%s.k%0d.busy", tag, k), 32'(bus.busy), 32'd1);
            if (k == 1) bus.req = bus.req & ~drop;
            if (k == set_k) bus.req = bus.req | ev;
            if (k == clr_k) bus.req = bus.req & ~ev;
        end
    endtask

    initial begin
        nvec     = 0;
        nmiss    = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        tick();
        tick();
        chk("reset.outputs", 32'(obs()), 32'd0);
        rst = 1'b0;
        expect_idle("post_reset");

        // Single request, A5 -> 1,0,1,0,0,1,0,1
        bus.data = {8'h00, 8'hA5};
        bus.req  = 2'b01;
        expect_word("single", 2'b01, 8'hA5, 2'b01, 0, 0, 2'b00);
        expect_idle("single.end");

        // Simultaneous after reset: requester 0 first, back-to-back
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.data = {8'h0F, 8'hF0};
        bus.req  = 2'b11;
        expect_word("simul.w0", 2'b01, 8'hF0, 2'b01, 0, 0, 2'b00);
        expect_word("simul.w1", 2'b10, 8'h0F, 2'b10, 0, 0, 2'b00);
        expect_idle("simul.end");

        // Fairness: both held, grants alternate with no gaps
        bus.data = {8'hC3, 8'h3C};
        bus.req  = 2'b11;
        expect_word("fair.w0", 2'b01, 8'h3C, 2'b00, 0, 0, 2'b00);
        expect_word("fair.w1", 2'b10, 8'hC3, 2'b00, 0, 0, 2'b00);
        expect_word("fair.w2", 2'b01, 8'h3C, 2'b00, 0, 0, 2'b00);
        expect_word("fair.w3", 2'b10, 8'hC3, 2'b11, 0, 0, 2'b00);
        expect_idle("fair.end");

        // Reset mid-word: serve requester 0 (ptr -> 1), abort at T+4
        bus.data = {8'h00, 8'hFF};
        bus.req  = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("rstmid.k%0d.sout", k), 32'(bus.sout), 32'd1);
            chk($sformatf("rstmid.k%0d.busy", k), 32'(bus.busy), 32'd1);
            if (k == 1) bus.req = '0;
        end
        rst = 1'b1;
        tick();
        chk("rstmid.t5.outputs", 32'(obs()), 32'd0);
        rst = 1'b0;
        expect_idle("rstmid.t6");
        bus.data = {8'hA5, 8'h5A};
        bus.req  = 2'b11;
        expect_word("rstmid.r0", 2'b01, 8'h5A, 2'b01, 0, 0, 2'b00);
        expect_word("rstmid.r1", 2'b10, 8'hA5, 2'b10, 0, 0, 2'b00);
        expect_idle("rstmid.end");

        // Late request: req[1] rises at T+3, granted at T+9
        bus.data = {8'h42, 8'h81};
        bus.req  = 2'b01;
        expect_word("late.w0", 2'b01, 8'h81, 2'b01, 3, 0, 2'b10);
        expect_word("late.w1", 2'b10, 8'h42, 2'b10, 0, 0, 2'b00);
        expect_idle("late.end");

        // Withdrawn: req[1] pulses at T+3 only, never granted
        bus.data = {8'h99, 8'hC3};
        bus.req  = 2'b01;
        expect_word("wdraw.w0", 2'b01, 8'hC3, 2'b01, 3, 4, 2'b10);
        expect_idle("wdraw.t9");
        expect_idle("wdraw.t10");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
